seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same 12-opcode set and 4-bit flag vector, generalised to WIDTH bits. Operands are registered on a valid/ready input, results are presented on a valid/ready output, and MUL/DIV are iterative multi-cycle operations. It sits between the calculator's operand/opcode front end and its result display/register stage.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 4.
FAST_MUL, 0, 0 = iterative shift-add multiply (WIDTH cycles); 1 = single-cycle multiply.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/opcode offer.
in_ready  output  1  block can accept an operation.
in_a  input  WIDTH  operand A, unsigned.
in_b  input  WIDTH  operand B, unsigned; also the shift amount.
in_op  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 AND, 7 OR, 8 XOR, 9 XNOR, A NAND, B NOR.
out_valid  output  1  result/flags valid.
out_ready  input  1  consumer accepts the result.
out_result  output  WIDTH  result.
out_flags  output  4  [0] Z zero, [1] C carry/shift-out, [2] V overflow/div-by-zero, [3] U underflow (A<B).
busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (synchronous, active-high): one clock; reset is synchronous and active-high. State goes to IDLE. out_valid=0, out_result=0, out_flags=0, busy=0, in_ready=1. Reset at any point, including mid-MUL/DIV, aborts the operation and discards its result.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a/b/op. Go to BUSY for iterative MUL (FAST_MUL=0) or for DIV with B!=0; otherwise go to DONE.
  - BUSY: iteration counter runs 0..WIDTH-1; go to DONE when it reaches WIDTH-1.
  - DONE: out_valid=1; result and flags are held stable. On out_ready, return to IDLE.
- No accept in the same cycle as the DONE->IDLE transition. Peak throughput is therefore one operation per 2 cycles.
- Latency from the accept edge to out_valid:
  - 1 cycle for single-cycle ops, including DIV by zero and MUL with FAST_MUL=1.
  - WIDTH+1 cycles for iterative MUL/DIV.
- Inputs are ignored outside IDLE; captured operands are never re-sampled.
- Arithmetic is unsigned and results are truncated to WIDTH bits.
  - ADD: C = carry out.
  - SUB: result = A + ~B + 1; U = (A<B).
  - MUL: result = low WIDTH bits of the product; V = high WIDTH bits nonzero.
  - DIV: result = floor(A/B) via restoring division; U = (A<B).
  - DIV by zero: result = all ones, V=1, U=0.
- Shifts (B is the amount):
  - If 1<=B<=WIDTH: SHL sets C=A[WIDTH-B]; SHR sets C=A[B-1].
  - If B=0: result=A, C=0.
  - If B>WIDTH: result=0, C=0.
- Logic ops: C=V=U=0.
- Z = (result==0) for every legal opcode.
- Illegal opcodes (C..F): result=0, all flags 0 (Z not set), 1-cycle latency.
- Flags not listed for an opcode are 0.

Decomposition:
- Package alu_pkg holds:
  - the op_e enum (4-bit, values above);
  - flag index constants FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_U=3;
  - the state_e enum (IDLE, BUSY, DONE).
- One sub-module, alu_iter_muldiv: shared WIDTH-cycle shift-add multiplier / restoring divider.
  - Ports: start, mode, a, b, done, result, hi_nonzero.
  - Driven by the seq_alu FSM.

Test Plan:
- WIDTH=8. ADD 0xF0+0x20 -> out_valid exactly 1 cycle after accept; result 0x10, flags C=1, Z=0. SUB 0x05-0x07 -> 0xFE, U=1.
- FAST_MUL=0. MUL 0x13*0x11 -> result 0x43, V=1, out_valid 9 cycles after accept, in_ready=0 throughout. MUL 0x0F*0x11 -> 0xFF, V=0.
- DIV 0xC8/0x07 -> 0x1C, U=0, latency 9. DIV 0x05/0x00 -> 0xFF, V=1, latency 1. DIV 0x03/0x09 -> 0x00, U=1, Z=1.
- SHL 0x81 by 1 -> 0x02, C=1. SHR 0x01 by 1 -> 0x00, C=1, Z=1. SHL 0xFF by 9 -> 0x00, C=0, Z=1. SHR 0x80 by 8 -> 0x00, C=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored. Then raise out_ready -> IDLE next cycle, queued op accepted the cycle after.
- Assert rst during DIV BUSY (cycle 4) -> next cycle IDLE, out_valid=0, outputs 0, in_ready=1. Then an illegal opcode 0xD -> result 0, flags 0000. Repeat all tests at WIDTH=16.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_XNOR = 4'h9,
        OP_NAND = 4'hA,
        OP_NOR  = 4'hB
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_U = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared WIDTH-step engine: shift-add multiplier or restoring divider over one 2*WIDTH register.
// done is combinational so the caller can leave BUSY on the edge that completes the last step.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nonzero
);

    localparam int CW = $clog2(WIDTH);

    // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg;
    logic               mode_reg;
    logic               running_reg;
    logic [CW-1:0]      cnt_reg;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;

    always_comb begin
        add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
        rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift[WIDTH-1:0] - opnd_reg;
        if (mode_reg == MODE_DIV) begin
            if (rem_shift >= {1'b0, opnd_reg})
                acc_next = {rem_diff, acc_reg[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc_reg[WIDTH-1:1]};
        end
    end

    assign done       = running_reg && (cnt_reg == CW'(WIDTH - 1));
    assign result     = acc_reg[WIDTH-1:0];
    assign hi_nonzero = |acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            opnd_reg    <= '0;
            mode_reg    <= MODE_MUL;
            running_reg <= 1'b0;
            cnt_reg     <= '0;
        end else if (start) begin
            acc_reg     <= (mode == MODE_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            opnd_reg    <= (mode == MODE_DIV) ? b : a;
            mode_reg    <= mode;
            running_reg <= 1'b1;
            cnt_reg     <= '0;
        end else if (running_reg) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done)
                running_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU: single-cycle ops are registered on accept, MUL/DIV iterate
// in alu_iter_muldiv, and the result is held in DONE until the consumer takes it.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             busy
);

    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic [3:0]         flags_reg, flags_next;
    logic               iter_reg, div_reg, lt_reg;

    op_e                op;
    logic               legal, iter_op, accept, md_start, md_done, md_hi;
    logic [WIDTH-1:0]   md_result;
    logic [3:0]         md_flags;
    logic [WIDTH:0]     add_full, shl_full, shr_full;
    logic [2*WIDTH-1:0] mul_full;

    assign op = op_e'(in_op);

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            assign mul_full = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
        end else begin : g_iter_mul
            assign mul_full = '0;
        end
    endgenerate

    // Shifting into an extra bit captures the last bit shifted out; amounts above WIDTH yield zero
    always_comb begin
        add_full    = {1'b0, in_a} + {1'b0, in_b};
        shl_full    = {1'b0, in_a} << in_b;
        shr_full    = {in_a, 1'b0} >> in_b;
        result_next = '0;
        flags_next  = '0;
        legal       = 1'b1;
        case (op)
            OP_ADD: begin
                result_next        = add_full[WIDTH-1:0];
                flags_next[FLAG_C] = add_full[WIDTH];
            end
            OP_SUB: begin
                result_next        = in_a + ~in_b + 1'b1;
                flags_next[FLAG_U] = (in_a < in_b);
            end
            OP_MUL: begin
                result_next        = mul_full[WIDTH-1:0];
                flags_next[FLAG_V] = |mul_full[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                result_next        = '1;
                flags_next[FLAG_V] = 1'b1;
            end
            OP_SHL:  {flags_next[FLAG_C], result_next} = shl_full;
            OP_SHR:  {result_next, flags_next[FLAG_C]} = shr_full;
            OP_AND:  result_next = in_a & in_b;
            OP_OR:   result_next = in_a | in_b;
            OP_XOR:  result_next = in_a ^ in_b;
            OP_XNOR: result_next = ~(in_a ^ in_b);
            OP_NAND: result_next = ~(in_a & in_b);
            OP_NOR:  result_next = ~(in_a | in_b);
            default: legal = 1'b0;
        endcase
        flags_next[FLAG_Z] = legal && (result_next == '0);
    end

    assign iter_op = ((op == OP_MUL) && (FAST_MUL == 0)) || ((op == OP_DIV) && (in_b != '0));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = iter_op ? BUSY : DONE;
                end
            end
            BUSY: if (md_done) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign md_start = accept && iter_op;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst        (rst),
        .start      (md_start),
        .mode       ((op == OP_DIV) ? MODE_DIV : MODE_MUL),
        .a          (in_a),
        .b          (in_b),
        .done       (md_done),
        .result     (md_result),
        .hi_nonzero (md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            flags_reg  <= '0;
            iter_reg   <= 1'b0;
            div_reg    <= 1'b0;
            lt_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                result_reg <= result_next;
                flags_reg  <= flags_next;
                iter_reg   <= iter_op;
                div_reg    <= (op == OP_DIV);
                lt_reg     <= (in_a < in_b);
            end
        end
    end

    always_comb begin
        md_flags         = '0;
        md_flags[FLAG_Z] = (md_result == '0);
        md_flags[FLAG_V] = !div_reg && md_hi;
        md_flags[FLAG_U] = div_reg && lt_reg;
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg == BUSY) || (state_reg == DONE);
    assign out_result = (state_reg == DONE) ? (iter_reg ? md_result : result_reg) : '0;
    assign out_flags  = (state_reg == DONE) ? (iter_reg ? md_flags : flags_reg) : '0;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8 and WIDTH=16 (iterative MUL): vector tables, backpressure and mid-op reset.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel16;
    logic        in_valid8, in_valid16, out_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_op;

    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  res8;
    logic [3:0]  flags8;
    logic        in_ready16, out_valid16, busy16;
    logic [15:0] res16;
    logic [3:0]  flags16;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8), .FAST_MUL(0)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_op(in_op),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_result(res8), .out_flags(flags8), .busy(busy8)
    );

    seq_alu #(.WIDTH(16), .FAST_MUL(0)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_result(res16), .out_flags(flags16), .busy(busy16)
    );

    logic        cur_in_ready, cur_out_valid, cur_busy;
    logic [15:0] cur_result;
    logic [3:0]  cur_flags;
    assign cur_in_ready  = sel16 ? in_ready16  : in_ready8;
    assign cur_out_valid = sel16 ? out_valid16 : out_valid8;
    assign cur_busy      = sel16 ? busy16      : busy8;
    assign cur_result    = sel16 ? res16       : {8'h00, res8};
    assign cur_flags     = sel16 ? flags16     : flags8;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_valid(input logic v);
        in_valid8  = v && !sel16;
        in_valid16 = v && sel16;
    endtask

    // Behavioural reference in plain integer arithmetic
    function automatic vec_t ref_model(input int w, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        vec_t   m;
        longint ua, ub, mask, r;
        bit     c, v, u, legal;
        ua = longint'(a); ub = longint'(b);
        mask = (64'sd1 <<< w) - 1;
        r = 0; c = 0; v = 0; u = 0; legal = 1;
        m.lat = 1;
        case (op)
            4'h0: begin r = (ua + ub) & mask; c = ((ua + ub) >> w) != 0; end
            4'h1: begin r = (ua - ub) & mask; u = ua < ub; end
            4'h2: begin r = (ua * ub) & mask; v = ((ua * ub) >> w) != 0; m.lat = w + 1; end
            4'h3: begin
                if (ub == 0) begin r = mask; v = 1; end
                else begin r = ua / ub; u = ua < ub; m.lat = w + 1; end
            end
            4'h4: begin
                if (ub == 0) r = ua;
                else if (ub <= w) begin r = (ua << ub) & mask; c = ((ua >> (w - ub)) & 1) != 0; end
            end
            4'h5: begin
                if (ub == 0) r = ua;
                else if (ub <= w) begin r = ua >> ub; c = ((ua >> (ub - 1)) & 1) != 0; end
            end
            4'h6: r = ua & ub;
            4'h7: r = ua | ub;
            4'h8: r = ua ^ ub;
            4'h9: r = ~(ua ^ ub) & mask;
            4'hA: r = ~(ua & ub) & mask;
            4'hB: r = ~(ua | ub) & mask;
            default: legal = 0;
        endcase
        m.op = op; m.a = a; m.b = b;
        m.res = r[15:0];
        m.flags = {u, v, c, legal && (r == 0)};
        return m;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flags, input int lat, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!cur_in_ready && n < 60) begin @(posedge clk); #1; n++; end
        check({tag, ".in_ready_idle"}, cur_in_ready, 1);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op;
        drive_valid(1'b1);
        @(posedge clk); #1;
        drive_valid(1'b0);
        e.res = res; e.flags = flags; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic collect(input string tag);
        int   lat;
        bit   rdy_seen;
        exp_t e;
        lat = 1; rdy_seen = 0;
        while (!cur_out_valid && lat < 60) begin
            rdy_seen |= cur_in_ready;
            @(posedge clk); #1;
            lat++;
        end
        rdy_seen |= cur_in_ready;
        check({tag, ".out_valid"}, cur_out_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".result"}, cur_result, e.res);
            check({tag, ".flags"}, cur_flags, e.flags);
            check({tag, ".latency"}, lat, e.lat);
            check({tag, ".in_ready_while_busy"}, rdy_seen, 0);
            $display("txn w=%0d op=%h a=%h b=%h res=%h flags=%b lat=%0d",
                     sel16 ? 16 : 8, in_op, in_a, in_b, cur_result, cur_flags, lat);
        end
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_after_ack"}, cur_out_valid, 0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic [3:0] flags, input int lat, input string tag);
        issue(op, a, b, res, flags, lat, tag);
        collect(tag);
        ack(tag);
    endtask

    task automatic backpressure(input string tag);
        issue(4'h0, 16'h000F, 16'h0001, 16'h0010, 4'b0000, 1, {tag, ".first"});
        collect({tag, ".first"});
        @(negedge clk);
        in_a = 16'h003C; in_b = 16'h000F; in_op = 4'h8;
        drive_valid(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check({tag, ".held_result"}, cur_result, 16'h0010);
            check({tag, ".held_flags"}, cur_flags, 4'b0000);
            check({tag, ".held_in_ready"}, cur_in_ready, 0);
            check({tag, ".held_out_valid"}, cur_out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".idle_out_valid"}, cur_out_valid, 0);
        check({tag, ".idle_in_ready"}, cur_in_ready, 1);
        @(posedge clk); #1;
        drive_valid(1'b0);
        begin
            exp_t e;
            e.res = 16'h0033; e.flags = 4'b0000; e.lat = 1;
            exp_q.push_back(e);
        end
        collect({tag, ".queued"});
        ack({tag, ".queued"});
    endtask

    task automatic reset_mid_div(input string tag);
        issue(4'h3, 16'h00C8, 16'h0007, 16'h001C, 4'b0000, 0, tag);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, ".busy_before_reset"}, cur_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check({tag, ".out_valid"}, cur_out_valid, 0);
        check({tag, ".result"}, cur_result, 16'h0000);
        check({tag, ".flags"}, cur_flags, 4'b0000);
        check({tag, ".in_ready"}, cur_in_ready, 1);
        check({tag, ".busy"}, cur_busy, 0);
        repeat (20) begin @(posedge clk); #1; end
        check({tag, ".no_stale_result"}, cur_out_valid, 0);
        run_op(4'hD, 16'h0005, 16'h0003, 16'h0000, 4'b0000, 1, {tag, ".illegal"});
    endtask

    vec_t t8[16];
    vec_t t16x[8];
    vec_t m;

    initial begin
        // op, a, b, result, flags{U,V,C,Z}, latency at WIDTH=8
        t8[0]  = '{4'h0, 16'h00F0, 16'h0020, 16'h0010, 4'b0010, 1};
        t8[1]  = '{4'h1, 16'h0005, 16'h0007, 16'h00FE, 4'b1000, 1};
        t8[2]  = '{4'h2, 16'h0013, 16'h0011, 16'h0043, 4'b0100, 9};
        t8[3]  = '{4'h2, 16'h000F, 16'h0011, 16'h00FF, 4'b0000, 9};
        t8[4]  = '{4'h3, 16'h00C8, 16'h0007, 16'h001C, 4'b0000, 9};
        t8[5]  = '{4'h3, 16'h0005, 16'h0000, 16'h00FF, 4'b0100, 1};
        t8[6]  = '{4'h3, 16'h0003, 16'h0009, 16'h0000, 4'b1001, 9};
        t8[7]  = '{4'h4, 16'h0081, 16'h0001, 16'h0002, 4'b0010, 1};
        t8[8]  = '{4'h5, 16'h0001, 16'h0001, 16'h0000, 4'b0011, 1};
        t8[9]  = '{4'h4, 16'h00FF, 16'h0009, 16'h0000, 4'b0001, 1};
        t8[10] = '{4'h5, 16'h0080, 16'h0008, 16'h0000, 4'b0011, 1};
        t8[11] = '{4'h4, 16'h0081, 16'h0000, 16'h0081, 4'b0000, 1};
        t8[12] = '{4'h6, 16'h00F0, 16'h003C, 16'h0030, 4'b0000, 1};
        t8[13] = '{4'h9, 16'h00AA, 16'h0055, 16'h0000, 4'b0001, 1};
        t8[14] = '{4'hB, 16'h0000, 16'h0000, 16'h00FF, 4'b0000, 1};
        t8[15] = '{4'hE, 16'h0012, 16'h0034, 16'h0000, 4'b0000, 1};

        // Extra 16-bit operands; expectations come from ref_model
        t16x[0] = '{4'h0, 16'hFFF0, 16'h0020, 16'h0, 4'h0, 0};
        t16x[1] = '{4'h2, 16'h1234, 16'h0011, 16'h0, 4'h0, 0};
        t16x[2] = '{4'h2, 16'hFFFF, 16'hFFFF, 16'h0, 4'h0, 0};
        t16x[3] = '{4'h3, 16'hC350, 16'h0007, 16'h0, 4'h0, 0};
        t16x[4] = '{4'h4, 16'h8001, 16'h0010, 16'h0, 4'h0, 0};
        t16x[5] = '{4'h5, 16'h8000, 16'h0010, 16'h0, 4'h0, 0};
        t16x[6] = '{4'h4, 16'hFFFF, 16'h0011, 16'h0, 4'h0, 0};
        t16x[7] = '{4'hA, 16'hFF00, 16'h0FF0, 16'h0, 4'h0, 0};

        rst = 1'b1; sel16 = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        drive_valid(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset8.out_valid", out_valid8, 0);
        check("reset8.in_ready", in_ready8, 1);
        check("reset8.busy", busy8, 0);
        check("reset8.result", res8, 0);
        check("reset8.flags", flags8, 0);
        check("reset16.out_valid", out_valid16, 0);
        check("reset16.in_ready", in_ready16, 1);
        check("reset16.result", res16, 0);
        rst = 1'b0;

        sel16 = 1'b0;
        for (int i = 0; i < 16; i++)
            run_op(t8[i].op, t8[i].a, t8[i].b, t8[i].res, t8[i].flags, t8[i].lat, $sformatf("w8.vec%0d", i));
        backpressure("w8.bp");
        reset_mid_div("w8.rst");

        sel16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m = ref_model(16, t8[i].op, t8[i].a, t8[i].b);
            run_op(m.op, m.a, m.b, m.res, m.flags, m.lat, $sformatf("w16.vec%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            m = ref_model(16, t16x[i].op, t16x[i].a, t16x[i].b);
            run_op(m.op, m.a, m.b, m.res, m.flags, m.lat, $sformatf("w16.ext%0d", i));
        end
        backpressure("w16.bp");
        reset_mid_div("w16.rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
